// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between two requesters and logic_unit_arbiter.
// LU_ARB_ZERO_FLAG_EN adds the rsp_zero flag alongside rsp_result.
interface logic_unit_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             busy;
`ifdef LU_ARB_ZERO_FLAG_EN
    logic             rsp_zero;
`endif

    // The arbiter side; the requesters (or a bench) use master.
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_result, busy
`ifdef LU_ARB_ZERO_FLAG_EN
        , output rsp_zero
`endif
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_result, busy
`ifdef LU_ARB_ZERO_FLAG_EN
        , input rsp_zero
`endif
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one AND/OR/XOR/NOR logic unit between two requesters.
// Optional LU_ARB_ZERO_FLAG_EN registers a result==0 flag next to the result.
module logic_unit_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    logic_unit_arbiter_if.slave bus
);

    localparam int NOR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             prio;
    logic             g;
    logic             grant_id;
    logic             any_valid;
    logic             take;
    logic             rsp_fire;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] lu_res;
    logic [NOR_W-1:0] nor_out;
`ifdef LU_ARB_ZERO_FLAG_EN
    logic             zero_q;
`endif

    assign any_valid = bus.req0_valid | bus.req1_valid;

    // A lone request wins regardless of prio; prio only breaks ties.
    assign grant_id = (bus.req0_valid & bus.req1_valid) ? prio : bus.req1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Ready is gated by rst_n so it reads 0 while reset is held even with a request present.
    always_comb begin
        state_n        = state;
        take           = 1'b0;
        rsp_fire       = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    take    = 1'b1;
                    state_n = EXEC;
                end
                bus.req0_ready = take & ~grant_id & rst_n;
                bus.req1_ready = take &  grant_id & rst_n;
            end
            EXEC: begin
                state_n = RESP;
            end
            RESP: begin
                bus.rsp0_valid = ~g;
                bus.rsp1_valid =  g;
                if (g ? bus.rsp1_ready : bus.rsp0_ready) begin
                    rsp_fire = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
            g    <= 1'b0;
            op_q <= 2'b00;
            a_q  <= '0;
            b_q  <= '0;
        end else begin
            if (take) begin
                g    <= grant_id;
                op_q <= grant_id ? bus.req1_op : bus.req0_op;
                a_q  <= grant_id ? bus.req1_a  : bus.req0_a;
                b_q  <= grant_id ? bus.req1_b  : bus.req0_b;
            end
            if (rsp_fire) begin
                prio <= ~g;
            end
        end
    end

    // The NOR path is the fixed 32-bit gate-level slice, hence WIDTH must be 32.
    for (genvar i = 0; i < NOR_W; i++) begin : g_nor
        nor u_nor (nor_out[i], a_q[i], b_q[i]);
    end

    always_comb begin
        lu_res = '0;
        case (op_q)
            2'b00:   lu_res = a_q & b_q;
            2'b01:   lu_res = a_q | b_q;
            2'b10:   lu_res = a_q ^ b_q;
            default: lu_res = nor_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (state == EXEC) begin
            res_q <= lu_res;
        end
    end

`ifdef LU_ARB_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else if (state == EXEC) begin
            zero_q <= (lu_res == '0);
        end
    end

    assign bus.rsp_zero = zero_q;
`endif

    assign bus.rsp_result = res_q;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed plus randomized bench for logic_unit_arbiter against a behavioural model.
// Build with +define+LU_ARB_ZERO_FLAG_EN to also cover rsp_zero.
module tb_logic_unit_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   exp_prio = 1'b0;

    always #5 clk = ~clk;

    logic_unit_arbiter_if #(.WIDTH(32)) bus ();

    logic_unit_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transaction for a single requester, optionally stalling the response.
    task automatic applyStimulus(input bit who, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int stall);
        logic [31:0] exp_res;
        int          waitc;
        exp_res = ref_op(op, a, b);
        if (who) begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
        #1;
        waitc = 0;
        while (((who ? bus.req1_ready : bus.req0_ready) !== 1'b1) && waitc < 20) begin
            tick();
            waitc++;
        end
        checkOutput("grant_wait", 32'(waitc), 32'd0);
        checkOutput("other_ready", who ? bus.req0_ready : bus.req1_ready, 0);
        checkOutput("busy_idle", bus.busy, 0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        checkOutput("exec_busy", bus.busy, 1);
        checkOutput("exec_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        tick();
        checkOutput("rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, who ? 2'b10 : 2'b01);
        checkOutput("rsp_result", bus.rsp_result, exp_res);
`ifdef LU_ARB_ZERO_FLAG_EN
        checkOutput("rsp_zero", bus.rsp_zero, (exp_res == 32'd0));
`endif
        if (who) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
        for (int i = 0; i < stall; i++) begin
            tick();
            checkOutput("stall_valid", {bus.rsp1_valid, bus.rsp0_valid}, who ? 2'b10 : 2'b01);
            checkOutput("stall_result", bus.rsp_result, exp_res);
        end
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        if (who) bus.rsp1_ready = 1'b1; else bus.rsp0_ready = 1'b1;
        tick();
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        exp_prio = ~who;
        checkOutput("done_busy", bus.busy, 0);
    endtask

    initial begin
        logic [31:0] res0, res1, bp_res;
        bit          gid;
        int          grants, cyc, last_cyc, pend, n;

        bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
        #2;
        checkOutput("reset_req0_ready", bus.req0_ready, 0);
        checkOutput("reset_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        checkOutput("reset_result", bus.rsp_result, 0);
        checkOutput("reset_busy", bus.busy, 0);
`ifdef LU_ARB_ZERO_FLAG_EN
        checkOutput("reset_zero", bus.rsp_zero, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.req0_valid = 1'b0;
        exp_prio = 1'b0;

        $display("[TB] directed operations");
        applyStimulus(1'b0, 2'b11, 32'h0000_00FF, 32'h0F00_0000, 0);
        for (int op = 0; op < 4; op++) begin
            applyStimulus(op[0], 2'(op), 32'hFFFF_0000, 32'h0F0F_0F0F, 1);
        end
        applyStimulus(1'b1, 2'b11, 32'h0000_0000, 32'h0000_0000, 0);
        applyStimulus(1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        $display("[TB] randomized transactions");
        for (int k = 0; k < 24; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        $display("[TB] contention");
        bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_a = 32'hFFFF_0000; bus.req0_b = 32'h0F0F_0F0F;
        bus.req1_valid = 1'b1; bus.req1_op = 2'b10; bus.req1_a = 32'hFFFF_0000; bus.req1_b = 32'h0F0F_0F0F;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        res0 = ref_op(2'b00, 32'hFFFF_0000, 32'h0F0F_0F0F);
        res1 = ref_op(2'b10, 32'hFFFF_0000, 32'h0F0F_0F0F);
        #1;
        grants = 0; cyc = 0; last_cyc = 0; pend = 0;
        while (grants < 6 && cyc < 40) begin
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                checkOutput("cont_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, pend ? 2'b10 : 2'b01);
                checkOutput("cont_result", bus.rsp_result, pend ? res1 : res0);
            end
            if (bus.req0_ready || bus.req1_ready) begin
                gid = bus.req1_ready;
                checkOutput("cont_onehot", bus.req0_ready & bus.req1_ready, 0);
                checkOutput("cont_grant_id", gid, exp_prio);
                if (grants > 0) checkOutput("cont_gap", 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                pend = int'(gid);
                exp_prio = ~gid;
                grants++;
            end
            if (grants < 6) begin
                tick();
                cyc++;
            end
        end
        checkOutput("cont_grants", 32'(grants), 32'd6);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        n = 0;
        while (bus.busy && n < 10) begin
            tick();
            n++;
        end
        checkOutput("cont_drain_busy", bus.busy, 0);
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;

        $display("[TB] back-pressure");
        bus.req1_valid = 1'b1; bus.req1_op = 2'b11; bus.req1_a = 32'h1234_5678; bus.req1_b = 32'h0000_FFFF;
        bp_res = ref_op(2'b11, 32'h1234_5678, 32'h0000_FFFF);
        #1;
        checkOutput("bp_grant1", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b01; bus.req0_a = 32'hA5A5_0000; bus.req0_b = 32'h0000_5A5A;
        checkOutput("bp_exec_ready0", bus.req0_ready, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 2'b10);
            checkOutput("bp_result", bus.rsp_result, bp_res);
            checkOutput("bp_busy", bus.busy, 1);
            checkOutput("bp_ready0", bus.req0_ready, 0);
            tick();
        end
        bus.rsp1_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready0", bus.req0_ready, 0);
        tick();
        bus.rsp1_ready = 1'b0;
        exp_prio = 1'b0;
        checkOutput("bp_next_grant0", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        checkOutput("bp_rsp0_result", bus.rsp_result, ref_op(2'b01, 32'hA5A5_0000, 32'h0000_5A5A));
        bus.rsp0_ready = 1'b1;
        tick();
        bus.rsp0_ready = 1'b0;
        exp_prio = 1'b1;

        $display("[TB] reset during response");
        bus.req0_valid = 1'b1; bus.req0_op = 2'b10; bus.req0_a = 32'hFFFF_FFFF; bus.req0_b = 32'h0000_0001;
        #1;
        checkOutput("rst_grant0", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_op = 2'b00; bus.req1_a = '0; bus.req1_b = '0;
        tick();
        checkOutput("rst_rsp0_valid_before", bus.rsp0_valid, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        checkOutput("rst_result", bus.rsp_result, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_ready1", bus.req1_ready, 0);
`ifdef LU_ARB_ZERO_FLAG_EN
        checkOutput("rst_zero", bus.rsp_zero, 0);
`endif
        tick();
        bus.req1_valid = 1'b0;
        rst_n = 1'b1;
        exp_prio = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_no_response", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        end
        applyStimulus(1'b1, 2'b00, 32'h0000_0000, 32'h0000_0000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a handshake never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one WIDTH-bit bitwise logic unit between two requesters. The unit does AND, OR, XOR and NOR, and its NOR path uses the gate-level 32-bit NOR. Each requester uses a valid/ready request channel and a valid/ready response channel. A 3-state FSM serialises operations, and a round-robin pointer prevents starvation. The block sits between the multi-cycle control unit and the ALU's logic slice.

## Interface
Parameters:
- WIDTH, 32, operand/result width. The only supported value is 32, because the NOR slice is fixed at 32 bits.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational)
- req0_op / req1_op  in  2  00 AND, 01 OR, 10 XOR, 11 NOR
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- rsp0_valid / rsp1_valid  out  1  result available for that requester
- rsp0_ready / rsp1_ready  in  1  requester consumes result
- rsp_result  out  WIDTH  shared result bus; qualified only by rspN_valid
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states:
  - IDLE: if any reqN_valid is high, grant one requester, assert its reqN_ready for that cycle, and latch op, a, b and the grant id g. Next state is EXEC.
  - EXEC: drive the latched operands into the logic unit and register the result into res_q. Next state is RESP.
  - RESP: assert rsp{g}_valid. When rsp{g}_ready is high, go to IDLE and set prio = ~g. Otherwise stay in RESP and hold res_q.
- Arbitration in IDLE:
  - Only one valid request: grant it, regardless of prio.
  - Both valid: grant the requester that prio points to.
  - prio resets to 0.
- The non-granted requester's ready is 0. Its operands are ignored until a later IDLE cycle.
- req_ready is never high outside IDLE. Requests arriving during EXEC or RESP wait.
- The result is fully WIDTH bits. There is no carry and no overflow.

## Timing
- Reset values: all reqN_ready = 0, rspN_valid = 0, rsp_result = 0, busy = 0, state = IDLE, prio = 0.
- Latency: handshake in cycle N, rsp_valid rises at N+2. The earliest rsp_ready accept is at N+2. The next grant is possible at N+3.
- Minimum interval between grants is 3 cycles.
- rsp_result is stable for the entire time rsp_valid is high.
- rsp_ready asserted in RESP for the non-granted requester has no effect.
- Back-pressure: RESP holds with no limit.
- Reset asserted mid-operation (EXEC or RESP): the pending operation is discarded. All outputs return to their reset values asynchronously, and no response is ever issued for that request.
- Simultaneous events: req valid during the RESP→IDLE transition cycle is not granted until the following cycle. That next IDLE cycle uses the updated prio.

## Configuration
- LU_ARB_ZERO_FLAG_EN:
  - When defined: adds output rsp_zero (1 bit). In EXEC it is registered as res == 0, it has the same valid qualification as rsp_result, and its reset value is 0.
  - When undefined: the port and its register do not exist, and all other behaviour is identical.

## Test plan
- Single NOR: req0 {op=11, a=0x0000_00FF, b=0x0F00_0000} accepted at cycle N → rsp0_valid at N+2 with rsp_result=0xF0FF_FF00 and rsp1_valid=0. With the macro, rsp_zero=0.
- Each op on a=0xFFFF_0000, b=0x0F0F_0F0F:
  - AND=0x0F0F_0000
  - OR=0xFFFF_0F0F
  - XOR=0xF0F0_0F0F
  - NOR=0x0000_F0F0
- Contention: req0 and req1 held valid continuously with rsp ready tied high → grants alternate 0,1,0,1, and each grant is 3 cycles after the previous one.
- Back-pressure: hold rsp1_ready=0 for 10 cycles → rsp1_valid and rsp_result stay constant, busy=1, and req0_ready=0 throughout. Releasing rsp1_ready lets req0 be granted 1 cycle later.
- Reset mid-RESP: drop rst_n while rsp0_valid=1 → outputs zero immediately. After rst_n returns, a fresh req1 {op=00, a=b=0} yields 0, and with the macro rsp_zero=1.
- NOR identity: a=b=0x0000_0000 → result 0xFFFF_FFFF. a=b=0xFFFF_FFFF → result 0.
